// File: rtl/wb_regfile.sv
// MIPS write-back stage and 2**ADDR_W x DATA_W architectural register file.
// Two bypassed combinational read ports, a registered debug read port and a saturating commit count.
module wb_regfile #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_mem_data,
   input  logic [DATA_W-1:0] wb_alu_data,
   input  logic [1:0]        wb_ctrl,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [CNT_W-1:0]  wr_count
);

   localparam int NumRegs = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [NumRegs];
   logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
   logic [CNT_W-1:0]  wr_count_q, wr_count_d;

   // Register 0 reads as zero; a write in flight to the addressed register wins.
   function automatic logic [DATA_W-1:0] bypass_read(input logic [ADDR_W-1:0] addr,
                                                     input logic              we,
                                                     input logic [ADDR_W-1:0] rd,
                                                     input logic [DATA_W-1:0] data,
                                                     input logic [DATA_W-1:0] stored);
      logic [DATA_W-1:0] val;
      val = stored;
      if (addr == '0) begin
         val = '0;
      end else if (we && (addr == rd)) begin
         val = data;
      end
      return val;
   endfunction

   always_comb begin
      wb_data = wb_ctrl[0] ? wb_mem_data : wb_alu_data;
      wb_we   = wb_ctrl[1] & ~rst & (wb_rd != '0);
   end

   always_comb begin
      rs_data    = bypass_read(rs_addr, wb_we, wb_rd, wb_data, regs_q[rs_addr]);
      rt_data    = bypass_read(rt_addr, wb_we, wb_rd, wb_data, regs_q[rt_addr]);
      dbg_data_d = bypass_read(dbg_addr, wb_we, wb_rd, wb_data, regs_q[dbg_addr]);
   end

   always_comb begin
      wr_count_d = wr_count_q;
      if (wb_we && (wr_count_q != {CNT_W{1'b1}})) begin
         wr_count_d = wr_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NumRegs; i++) begin
            regs_q[i] <= '0;
         end
         dbg_data_q <= '0;
         wr_count_q <= '0;
      end else begin
         if (wb_we) begin
            regs_q[wb_rd] <= wb_data;
         end
         dbg_data_q <= dbg_data_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign dbg_data = dbg_data_q;
   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed literal checks plus randomized traffic
// compared every cycle against a behavioural register-file model (32-bit and 4-bit counters).
module tb_wb_regfile;

   logic        clk;
   logic        rst;
   logic [4:0]  wb_rd;
   logic [31:0] wb_mem_data;
   logic [31:0] wb_alu_data;
   logic [1:0]  wb_ctrl;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [4:0]  dbg_addr;

   logic [31:0] rs_data, rt_data, wb_data, dbg_data, wr_count;
   logic        wb_we;
   logic [31:0] rs_data4, rt_data4, wb_data4, dbg_data4;
   logic [3:0]  wr_count4;
   logic        wb_we4;

   wb_regfile dut (
      .clk        (clk),
      .rst        (rst),
      .wb_rd      (wb_rd),
      .wb_mem_data(wb_mem_data),
      .wb_alu_data(wb_alu_data),
      .wb_ctrl    (wb_ctrl),
      .rs_addr    (rs_addr),
      .rt_addr    (rt_addr),
      .rs_data    (rs_data),
      .rt_data    (rt_data),
      .wb_data    (wb_data),
      .wb_we      (wb_we),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data),
      .wr_count   (wr_count)
   );

   wb_regfile #(.CNT_W(4)) dut4 (
      .clk        (clk),
      .rst        (rst),
      .wb_rd      (wb_rd),
      .wb_mem_data(wb_mem_data),
      .wb_alu_data(wb_alu_data),
      .wb_ctrl    (wb_ctrl),
      .rs_addr    (rs_addr),
      .rt_addr    (rt_addr),
      .rs_data    (rs_data4),
      .rt_data    (rt_data4),
      .wb_data    (wb_data4),
      .wb_we      (wb_we4),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data4),
      .wr_count   (wr_count4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: architectural register contents and unbounded commit count.
   logic [31:0] m_regs [32];
   logic [31:0] m_dbg;
   int unsigned m_commits;
   logic        m_valid = 1'b0;

   function automatic logic [31:0] m_sel();
      return wb_ctrl[0] ? wb_mem_data : wb_alu_data;
   endfunction

   function automatic logic m_we();
      return wb_ctrl[1] && !rst && (wb_rd != 5'd0);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (m_we() && a == wb_rd) return m_sel();
      return m_regs[a];
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
         m_dbg     <= 32'd0;
         m_commits <= 0;
         m_valid   <= 1'b1;
      end else begin
         if (m_we()) begin
            m_regs[wb_rd] <= m_sel();
            m_commits     <= m_commits + 1;
         end
         m_dbg <= m_read(dbg_addr);
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      check("wb_data", wb_data, m_sel());
      check("wb_data4", wb_data4, m_sel());
      if (m_valid) begin
         check("wb_we", {31'd0, wb_we}, {31'd0, m_we()});
         check("wb_we4", {31'd0, wb_we4}, {31'd0, m_we()});
         check("rs_data", rs_data, m_read(rs_addr));
         check("rt_data", rt_data, m_read(rt_addr));
         check("rs_data4", rs_data4, m_read(rs_addr));
         check("rt_data4", rt_data4, m_read(rt_addr));
         check("dbg_data", dbg_data, m_dbg);
         check("dbg_data4", dbg_data4, m_dbg);
         check("wr_count", wr_count, m_commits);
         check("wr_count4", {28'd0, wr_count4}, (m_commits > 15) ? 32'd15 : m_commits);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wb_ctrl     = 2'b00;
      wb_rd       = 5'd0;
      wb_mem_data = 32'd0;
      wb_alu_data = 32'd0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      rs_addr  = 5'd0;
      rt_addr  = 5'd0;
      dbg_addr = 5'd0;

      // Reset then read
      step();
      step();
      rst      = 1'b0;
      rs_addr  = 5'd5;
      rt_addr  = 5'd31;
      dbg_addr = 5'd7;
      settle();
      check("lit_reset_rs", rs_data, 32'd0);
      check("lit_reset_rt", rt_data, 32'd0);
      check("lit_reset_cnt", wr_count, 32'd0);
      step();
      settle();
      check("lit_reset_dbg", dbg_data, 32'd0);

      // ALU write-back
      step();
      wb_ctrl     = 2'b10;
      wb_rd       = 5'd8;
      wb_alu_data = 32'h0000_1234;
      wb_mem_data = 32'hDEAD_BEEF;
      settle();
      check("lit_alu_wbdata", wb_data, 32'h0000_1234);
      check("lit_alu_we", {31'd0, wb_we}, 32'd1);
      step();
      idle_inputs();
      rs_addr = 5'd8;
      settle();
      check("lit_alu_r8", rs_data, 32'h0000_1234);
      check("lit_alu_cnt", wr_count, 32'd1);

      // Load write-back with same-cycle bypass
      step();
      wb_ctrl     = 2'b11;
      wb_rd       = 5'd9;
      wb_mem_data = 32'hCAFE_F00D;
      wb_alu_data = 32'h1111_1111;
      rs_addr     = 5'd9;
      rt_addr     = 5'd9;
      dbg_addr    = 5'd9;
      settle();
      check("lit_load_rs", rs_data, 32'hCAFE_F00D);
      check("lit_load_rt", rt_data, 32'hCAFE_F00D);
      step();
      idle_inputs();
      settle();
      check("lit_load_dbg", dbg_data, 32'hCAFE_F00D);
      check("lit_load_cnt", wr_count, 32'd2);

      // Write to r0 is dropped
      step();
      wb_ctrl     = 2'b10;
      wb_rd       = 5'd0;
      wb_alu_data = 32'hFFFF_FFFF;
      rs_addr     = 5'd0;
      settle();
      check("lit_r0_we", {31'd0, wb_we}, 32'd0);
      check("lit_r0_rs", rs_data, 32'd0);
      // RegWrite clear: no commit, no bypass
      step();
      wb_ctrl     = 2'b01;
      wb_rd       = 5'd4;
      wb_mem_data = 32'hABCD_0004;
      rs_addr     = 5'd4;
      settle();
      check("lit_nowr_we", {31'd0, wb_we}, 32'd0);
      check("lit_nowr_rs", rs_data, 32'd0);
      check("lit_r0_cnt", wr_count, 32'd2);
      step();
      idle_inputs();
      settle();
      check("lit_nowr_r4", rs_data, 32'd0);
      check("lit_nowr_cnt", wr_count, 32'd2);

      // Reset during write, then the same entry commits once rst drops
      step();
      rst         = 1'b1;
      wb_ctrl     = 2'b10;
      wb_rd       = 5'd3;
      wb_alu_data = 32'h55;
      rs_addr     = 5'd3;
      settle();
      check("lit_rstwr_we", {31'd0, wb_we}, 32'd0);
      step();
      rst = 1'b0;
      settle();
      check("lit_rstwr_r3_pre", rs_data, 32'h55);
      check("lit_rstwr_cnt0", wr_count, 32'd0);
      step();
      idle_inputs();
      settle();
      check("lit_rstwr_r3", rs_data, 32'h55);
      check("lit_rstwr_cnt1", wr_count, 32'd1);

      // Counter saturation: 17 commits, 4-bit counter stops at 15
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 1; i <= 17; i++) begin
         wb_ctrl     = 2'b10;
         wb_rd       = 5'(i);
         wb_alu_data = 32'h100 + 32'(i);
         step();
      end
      idle_inputs();
      settle();
      check("lit_sat_cnt4", {28'd0, wr_count4}, 32'd15);
      check("lit_sat_cnt32", wr_count, 32'd17);
      for (int i = 1; i <= 17; i++) begin
         rs_addr = 5'(i);
         #1;
         check("lit_sat_reg", rs_data4, 32'h100 + 32'(i));
      end

      // Randomized traffic with occasional mid-stream reset
      for (int n = 0; n < 3000; n++) begin
         step();
         rst         = ($urandom_range(0, 49) == 0);
         wb_ctrl     = 2'($urandom_range(0, 3));
         wb_rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
         wb_mem_data = $urandom;
         wb_alu_data = $urandom;
         rs_addr     = ($urandom_range(0, 3) == 0) ? wb_rd : 5'($urandom_range(0, 31));
         rt_addr     = ($urandom_range(0, 3) == 0) ? wb_rd : 5'($urandom_range(0, 31));
         dbg_addr    = ($urandom_range(0, 3) == 0) ? wb_rd : 5'($urandom_range(0, 31));
      end
      step();
      idle_inputs();
      rst = 1'b0;
      settle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
